// File: rtl/rvc_fetch_aligner_if.sv
`default_nettype none
// ============================================================================
// Module   : rvc_fetch_aligner_if
// Purpose  : Fetch-side and decode-side handshake bundle for the RVC aligner,
//            including the redirect (flush) request.
// Revision : 1.0 - initial release
// ============================================================================
interface rvc_fetch_aligner_if;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic        inst_is_c_o;
  logic [31:0] inst_pc_o;

  // Environment side: supplies fetch words, redirects and decode readiness
  modport master (
    output flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, inst_ready_i,
    input  fetch_ready_o, inst_valid_o, inst_o, inst_is_c_o, inst_pc_o
  );

  // Aligner side
  modport slave (
    input  flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, inst_ready_i,
    output fetch_ready_o, inst_valid_o, inst_o, inst_is_c_o, inst_pc_o
  );
endinterface
`default_nettype wire

// File: rtl/rvc_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : rvc_fetch_aligner
// Purpose  : Turns a stream of word-aligned 32-bit fetch words into one
//            aligned 16/32-bit instruction per handshake, with PC and RVC flag.
// Revision : 1.0 - initial release
// ============================================================================
module rvc_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  rvc_fetch_aligner_if.slave bus
);

  // Three-entry halfword buffer, entry 0 is the oldest (instruction head)
  logic [15:0] hb_q [3];
  logic [15:0] hb_d [3];
  logic [1:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic        skip_q, skip_d;

  logic        head_is_c;
  logic        head_valid;
  logic        fetch_ready;
  logic        accept;
  logic        pop;
  logic [1:0]  pop_n;
  logic [1:0]  push_n;
  logic [1:0]  keep;
  logic [15:0] push_lo;

  // Head decode and handshake qualification (state-only ready/valid)
  always_comb begin
    head_is_c   = (hb_q[0][1:0] != 2'b11);
    head_valid  = head_is_c ? (count_q != 2'd0) : (count_q >= 2'd2);
    fetch_ready = (count_q <= 2'd1);
    accept      = bus.fetch_valid_i & fetch_ready & ~bus.flush_i;
    pop         = head_valid & bus.inst_ready_i & ~bus.flush_i;
    pop_n       = pop ? (head_is_c ? 2'd1 : 2'd2) : 2'd0;
    push_n      = accept ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
    keep        = count_q - pop_n;
    // After a redirect to an odd-halfword PC the lower half is dead
    push_lo     = skip_q ? bus.fetch_data_i[31:16] : bus.fetch_data_i[15:0];
  end

  // Next-state: shift out popped halfwords, then append the accepted word
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hb_d[i] = hb_q[i];
      if (3'(i) < {1'b0, keep}) begin
        hb_d[i] = hb_q[2'(3'(i) + {1'b0, pop_n})];
      end else if ((3'(i) - {1'b0, keep}) < {1'b0, push_n}) begin
        hb_d[i] = ((3'(i) - {1'b0, keep}) == 3'd0) ? push_lo
                                                   : bus.fetch_data_i[31:16];
      end
    end
    count_d = keep + push_n;
    pc_d    = pc_q + {29'd0, pop_n, 1'b0};
    skip_d  = accept ? 1'b0 : skip_q;
    if (bus.flush_i) begin
      count_d = 2'd0;
      pc_d    = bus.flush_pc_i;
      skip_d  = bus.flush_pc_i[1];
    end
  end

  // State register; reset dominates flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) hb_q[i] <= 16'h0000;
      count_q <= 2'd0;
      pc_q    <= RESET_PC;
      skip_q  <= RESET_PC[1];
    end else begin
      for (int i = 0; i < 3; i++) hb_q[i] <= hb_d[i];
      count_q <= count_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
    end
  end

  // Outputs; the upper half is masked until the second halfword is present
  always_comb begin
    bus.fetch_ready_o = fetch_ready;
    bus.inst_valid_o  = head_valid;
    bus.inst_pc_o     = pc_q;
    bus.inst_is_c_o   = (count_q != 2'd0) & head_is_c;
    if (count_q == 2'd0) begin
      bus.inst_o = 32'h0000_0000;
    end else if (head_is_c) begin
      bus.inst_o = {16'h0000, hb_q[0]};
    end else begin
      bus.inst_o = {(count_q >= 2'd2) ? hb_q[1] : 16'h0000, hb_q[0]};
    end
  end

endmodule
`default_nettype wire
